// File: rtl/sobel_window.sv
// ============================================================================
// sobel_window
// ----------------------------------------------------------------------------
// Streaming 3x3 window generator for the sobel gradient stage. It takes a
// raster-order pixel stream, keeps the previous two rows in line buffers and
// emits the eight neighbour taps (p4, the centre, is not needed by sobel) for
// every interior pixel position. There is one registered window per accepted
// pixel at most.
//
// Parameters:
//   IMG_W   pixels per row (>= 3)
//   IMG_H   rows per frame (>= 3)
//   PIX_W   input pixel width; taps are PIX_W+1 bits, zero-extended
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_pixel accepted this cycle (no backpressure)
//   in_pixel   pixel, row-major raster order
//   in_sof     start of frame, qualified by in_valid (only with SOBEL_WIN_SOF_EN)
//   out_valid  window taps valid this cycle
//   p0..p8     window taps (no p4): top p0 p1 p2, middle p3 p5, bottom p6 p7 p8
//   out_last   final window of the frame, qualified by out_valid
//
// Configuration macro:
//   SOBEL_WIN_SOF_EN  adds in_sof; an accepted pixel with in_sof=1 is treated
//                     as position (0,0). Without it the counters free-run.
// ============================================================================
module sobel_window #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
`ifdef SOBEL_WIN_SOF_EN
    input  logic             in_sof,
`endif
    output logic             out_valid,
    output logic [PIX_W:0]   p0,
    output logic [PIX_W:0]   p1,
    output logic [PIX_W:0]   p2,
    output logic [PIX_W:0]   p3,
    output logic [PIX_W:0]   p5,
    output logic [PIX_W:0]   p6,
    output logic [PIX_W:0]   p7,
    output logic [PIX_W:0]   p8,
    output logic             out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Line buffers: r_lb1 holds row r-1, r_lb2 holds row r-2.
    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;

    // Window columns. The newest column (c) is the live line-buffer read plus
    // the incoming pixel, so only columns c-1 (A) and c-2 (B) are stored.
    logic [PIX_W-1:0] r_topA, r_topB;
    logic [PIX_W-1:0] r_midA, r_midB;
    logic [PIX_W-1:0] r_botA, r_botB;

    logic             w_sof;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic [PIX_W-1:0] w_top;
    logic [PIX_W-1:0] w_mid;
    logic             w_emit;
    logic             w_last;

`ifdef SOBEL_WIN_SOF_EN
    assign w_sof = in_sof;
`else
    assign w_sof = 1'b0;
`endif

    // Effective position of the pixel being accepted: a start-of-frame pixel
    // is placed at (0,0) regardless of where the counters were, so the line
    // buffers and emission gating see the new frame's coordinates at once.
    always_comb begin
        w_col  = r_col;
        w_row  = r_row;
        if (in_valid && w_sof) begin
            w_col = '0;
            w_row = '0;
        end
        w_top  = r_lb2[w_col];
        w_mid  = r_lb1[w_col];
        // Requiring c>=2 keeps row-straddling columns out of every window and
        // r>=2 ensures both buffered rows belong to the current frame.
        w_emit = in_valid && (w_row >= ROW_TWO) && (w_col >= COL_TWO);
        w_last = (w_row == ROW_LAST) && (w_col == COL_LAST);
    end

    // Position counters advance only on accepted pixels and wrap per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Line buffers age one row per visit to a column; no reset needed since
    // rows 0 and 1 of every frame are written before they are read for output.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb2[w_col] <= w_mid;
            r_lb1[w_col] <= in_pixel;
        end
    end

    // Shift the new column into the window and drop the oldest one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_topA <= '0;
            r_topB <= '0;
            r_midA <= '0;
            r_midB <= '0;
            r_botA <= '0;
            r_botB <= '0;
        end else if (in_valid) begin
            r_topB <= r_topA;
            r_topA <= w_top;
            r_midB <= r_midA;
            r_midA <= w_mid;
            r_botB <= r_botA;
            r_botA <= in_pixel;
        end
    end

    // Output register: taps load only when a window completes and otherwise
    // hold, while the valid/last strobes last exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
            p5 <= '0;
            p6 <= '0;
            p7 <= '0;
            p8 <= '0;
        end else begin
            out_valid <= w_emit;
            out_last  <= w_emit && w_last;
            if (w_emit) begin
                p0 <= {1'b0, r_topB};
                p1 <= {1'b0, r_topA};
                p2 <= {1'b0, w_top};
                p3 <= {1'b0, r_midB};
                p5 <= {1'b0, w_mid};
                p6 <= {1'b0, r_botB};
                p7 <= {1'b0, r_botA};
                p8 <= {1'b0, in_pixel};
            end
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// ============================================================================
// tb_sobel_window
// ----------------------------------------------------------------------------
// Self-checking bench for sobel_window with IMG_W=8, IMG_H=6. A behavioural
// model stores the frame as a 2-D image and, for each accepted pixel at
// (r,c) with r,c >= 2, predicts the window from image coordinates. A compare
// process checks the DUT against the model every cycle, and the recorded
// window sequences are pinned against hand-computed values.
// ============================================================================
module tb_sobel_window;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = '0;
`ifdef SOBEL_WIN_SOF_EN
    logic       in_sof = 1'b0;
`endif
    logic       out_valid;
    logic       out_last;
    logic [8:0] p0, p1, p2, p3, p5, p6, p7, p8;
    logic [71:0] dutWin;

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;

    // Model state
    logic [7:0]  img [H][W];
    int          mRow = 0;
    int          mCol = 0;
    logic        eValid = 1'b0;
    logic        eLast = 1'b0;
    logic [71:0] eWin = '0;

    // Windows observed from the DUT, in order
    logic [71:0] dutLog [$];
    bit          lastLog [$];

    sobel_window #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_pixel (in_pixel),
`ifdef SOBEL_WIN_SOF_EN
        .in_sof   (in_sof),
`endif
        .out_valid(out_valid),
        .p0       (p0),
        .p1       (p1),
        .p2       (p2),
        .p3       (p3),
        .p5       (p5),
        .p6       (p6),
        .p7       (p7),
        .p8       (p8),
        .out_last (out_last)
    );

    assign dutWin = {p0, p1, p2, p3, p5, p6, p7, p8};

    always #5 clk = ~clk;

    function automatic logic [8:0] tap(input int r, input int c);
        return {1'b0, img[r][c]};
    endfunction

    // Reference model: place each accepted pixel in the image and, when it
    // completes a window, predict that window for the next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRow   = 0;
            mCol   = 0;
            eValid = 1'b0;
            eLast  = 1'b0;
            eWin   = '0;
        end else begin
            eValid = 1'b0;
            eLast  = 1'b0;
            if (in_valid) begin
`ifdef SOBEL_WIN_SOF_EN
                if (in_sof) begin
                    mRow = 0;
                    mCol = 0;
                end
`endif
                img[mRow][mCol] = in_pixel;
                if (mRow >= 2 && mCol >= 2) begin
                    eValid = 1'b1;
                    eLast  = (mRow == H - 1) && (mCol == W - 1);
                    eWin   = {tap(mRow-2, mCol-2), tap(mRow-2, mCol-1), tap(mRow-2, mCol),
                              tap(mRow-1, mCol-2), tap(mRow-1, mCol),
                              tap(mRow, mCol-2), tap(mRow, mCol-1), tap(mRow, mCol)};
                end
                mCol = mCol + 1;
                if (mCol == W) begin
                    mCol = 0;
                    mRow = (mRow == H - 1) ? 0 : mRow + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            testsRun++;
            if (out_valid !== eValid) begin
                testsFailed++;
                $display("[TB] FAIL out_valid: got %b, want %b at %0t", out_valid, eValid, $time);
            end
            testsRun++;
            if (dutWin !== eWin) begin
                testsFailed++;
                $display("[TB] FAIL taps: got %h, want %h at %0t", dutWin, eWin, $time);
            end
            if (eValid) begin
                testsRun++;
                if (out_last !== eLast) begin
                    testsFailed++;
                    $display("[TB] FAIL out_last: got %b, want %b at %0t", out_last, eLast, $time);
                end
            end
            if (out_valid) begin
                dutLog.push_back(dutWin);
                lastLog.push_back(out_last);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Stream nPix pixels; pixel i sits at raster index i mod 48 and takes the
    // value index+offset, 255, or a random value. gapPct inserts idle cycles.
    task automatic applyStimulus(input int nPix, input int gapPct, input int offset,
                                 input bit allOnes, input bit randPix, input bit sofFirst);
        for (int i = 0; i < nPix; i++) begin
            int pos;
            pos = i % (W * H);
            if (gapPct > 0) begin
                for (int g = 0; g < 4 && $urandom_range(99) < gapPct; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            if (allOnes)
                in_pixel = 8'hFF;
            else if (randPix)
                in_pixel = 8'($urandom);
            else
                in_pixel = 8'(pos + offset);
`ifdef SOBEL_WIN_SOF_EN
            in_sof = sofFirst && (i == 0);
`else
            if (sofFirst) $display("[TB] note: in_sof not built, ignored");
`endif
        end
        @(negedge clk);
        in_valid = 1'b0;
`ifdef SOBEL_WIN_SOF_EN
        in_sof = 1'b0;
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic clearLog();
        dutLog.delete();
        lastLog.delete();
    endtask

    // Hand-computed ramp windows (value = 8*row + col)
    localparam logic [71:0] RAMP_FIRST = {9'd0, 9'd1, 9'd2, 9'd8, 9'd10, 9'd16, 9'd17, 9'd18};
    localparam logic [71:0] RAMP_LAST  = {9'd29, 9'd30, 9'd31, 9'd37, 9'd39, 9'd45, 9'd46, 9'd47};

    task automatic checkRampFrame(input string tag);
        int lastCount;
        checkOutput({tag, "Count"}, 72'(dutLog.size()), 72'd24);
        if (dutLog.size() == 24) begin
            checkOutput({tag, "First"}, dutLog[0], RAMP_FIRST);
            checkOutput({tag, "Last"}, dutLog[23], RAMP_LAST);
            checkOutput({tag, "LastFlag"}, 72'(lastLog[23]), 72'd1);
            lastCount = 0;
            foreach (lastLog[k]) lastCount += int'(lastLog[k]);
            checkOutput({tag, "LastOnce"}, 72'(lastCount), 72'd1);
        end
    endtask

    initial begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("resetTaps", dutWin, '0);
        checkOutput("resetStrobes", {70'd0, out_valid, out_last}, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        checkEn = 1'b1;

        // 1: continuous ramp frame
        clearLog();
        applyStimulus(48, 0, 0, 1'b0, 1'b0, 1'b0);
        checkRampFrame("ramp");

        // 2: same frame with random gaps
        clearLog();
        applyStimulus(48, 50, 0, 1'b0, 1'b0, 1'b0);
        checkRampFrame("gaps");

        // 3: all pixels 255
        clearLog();
        applyStimulus(48, 0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("onesCount", 72'(dutLog.size()), 72'd24);
        foreach (dutLog[k]) checkOutput("onesTaps", dutLog[k], {8{9'h0FF}});

        // 4: reset after pixel (3,4), then a fresh frame
        applyStimulus(29, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midResetTaps", dutWin, '0);
        checkOutput("midResetStrobes", {70'd0, out_valid, out_last}, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        clearLog();
        applyStimulus(48, 0, 0, 1'b0, 1'b0, 1'b0);
        checkRampFrame("afterReset");

`ifdef SOBEL_WIN_SOF_EN
        // 5: in_sof on what would be A(3,4); frame B values +100
        clearLog();
        applyStimulus(28, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(48, 0, 100, 1'b0, 1'b0, 1'b1);
        checkOutput("sofCount", 72'(dutLog.size()), 72'd32);
        if (dutLog.size() == 32)
            checkOutput("sofFirstB", dutLog[8],
                        {9'd100, 9'd101, 9'd102, 9'd108, 9'd110, 9'd116, 9'd117, 9'd118});
`else
        // 6: 96 pixels back-to-back, counters free-run across frames
        clearLog();
        applyStimulus(96, 0, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("twoFrameCount", 72'(dutLog.size()), 72'd48);
        if (dutLog.size() == 48) begin
            checkOutput("lastW24", 72'(lastLog[23]), 72'd1);
            checkOutput("lastW48", 72'(lastLog[47]), 72'd1);
            checkOutput("firstW25", dutLog[24], RAMP_FIRST);
        end
`endif

        // Random pixels with random gaps over two frames
        clearLog();
        applyStimulus(96, 30, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("randCount", 72'(dutLog.size()), 72'd48);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
